axi_imem_rd_slave: RTL and testbench
====================================

Name: axi_imem_rd_slave

Overview:
- AXI4 read-only instruction memory slave that drives the core's I-side AXI read channel (`axi_i_ar*` / `axi_i_r*` on `riscv_top`).
- Holds program words in an internal word array, preloaded through a simple load port driven by the bench or boot loader.
- Serves FIXED, INCR and WRAP bursts for I-cache line fills.
- Write channels are not part of this block.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of word 0.
- DEPTH_WORDS, 1024, number of 32-bit words; must be a power of two.
- ID_W, 4, AXI ID width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-low.
- load_en_i  in  1  preload write strobe.
- load_addr_i  in  32  preload byte address; bits [1:0] ignored.
- load_data_i  in  32  preload word.
- arvalid_i  in  1  AR valid.
- araddr_i  in  32  AR byte address.
- arid_i  in  ID_W  AR ID.
- arlen_i  in  8  beats minus 1.
- arburst_i  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
- arready_o  out  1  AR ready.
- rvalid_o  out  1  R valid.
- rdata_o  out  32  R data.
- rresp_o  out  2  00 OKAY, 10 SLVERR.
- rid_o  out  ID_W  equals the accepted arid_i.
- rlast_o  out  1  final beat.
- rready_i  in  1  R ready.

Behaviour:
- Reset: sampled on clk_i rising edge while rst_i==0.
  - Outputs after reset: arready_o=0, rvalid_o=0, rdata_o=0, rresp_o=0, rid_o=0, rlast_o=0; state=IDLE.
  - The memory array is not cleared.
  - arready_o rises in the first cycle after rst_i returns to 1.
- States: IDLE and BURST.
- IDLE:
  - arready_o=1 and rvalid_o=0.
  - On arvalid_i && arready_o, latch addr, len, id and burst; beat count = 0; go to BURST.
  - arready_o=0 from the next cycle.
- Read latency: the first beat's rvalid_o is asserted in the cycle after AR acceptance.
- R-channel hold rule: while rvalid_o && !rready_i, rdata_o, rresp_o, rid_o and rlast_o are held stable.
- Beat advance:
  - Each rvalid_o && rready_i advances the address and count.
  - The next beat is presented in the following cycle, so back-to-back beats stream at 1 beat/cycle when rready_i is held high.
- rlast_o is 1 exactly on beat count == len.
- Last beat accepted:
  - rvalid_o=0 next cycle, state returns to IDLE, arready_o=1 next cycle.
  - There is no AR/R overlap, so there is a minimum 1 idle cycle between bursts.
- Address sequence (addr[1:0] forced to 0):
  - FIXED: constant address.
  - INCR: +4 per beat, 32-bit wraparound.
  - WRAP: +4 within the block of (len+1)*4 bytes aligned to that size.
- Error cases, SLVERR with rdata_o=0:
  - WRAP with len not in {1,3,7,15}: every beat of the burst is SLVERR.
  - Reserved burst 11: every beat of the burst is SLVERR.
- Range check per beat:
  - A beat is in range when BASE_ADDR <= addr < BASE_ADDR + DEPTH_WORDS*4.
  - Out-of-range beats are SLVERR with rdata_o=0.
  - Other beats of the same burst are unaffected.
- Data path:
  - Index = (addr - BASE_ADDR) >> 2.
  - Data is registered and taken from the array in the cycle before presentation.
- Preload:
  - When load_en_i && rst_i, write the word at the index derived from load_addr_i.
  - Out-of-range loads are dropped silently.
  - A load is accepted in any state.
  - A load in cycle N is visible to any beat whose data is fetched in cycle N+1 or later.
  - A beat already registered keeps its old data.
- Reset mid-burst: rvalid_o=0 at the reset edge and the burst is abandoned; no rlast_o is produced.
- arvalid_i while in BURST is ignored because arready_o=0; the master must hold it until accepted.

Test Plan:
- Preload 4 words from a trace (0x0→0x00000093, 0x4→0x00100113, 0x8→0x00200193, 0xC→0x00300213), then INCR araddr=0x0, arlen=3, arid=5, rready held 1 → rvalid_o rises 1 cycle after the handshake; 4 consecutive beats carry those words; rid_o=5 on every beat; rresp_o=OKAY; rlast_o on beat 4 only; arready_o=1 the cycle after.
- WRAP araddr=0x8, arlen=3 → data sequence words @0x8, 0xC, 0x0, 0x4; rlast_o on the 4th beat.
- Backpressure: rready_i toggling 1,0,0,1,… during an INCR arlen=3 burst → data and rlast_o held stable while stalled; no beat lost or duplicated; total 4 handshakes.
- Errors:
  - INCR araddr=DEPTH_WORDS*4-4, arlen=1 → beat 1 OKAY, beat 2 SLVERR with rdata_o=0.
  - WRAP arlen=2 → both beats SLVERR.
  - burst=11 → all beats SLVERR.
- FIXED araddr=0x4, arlen=2 → three beats all 0x00100113; preload 0x4←0xDEADBEEF in the cycle of beat 1's handshake → beat 3 returns 0xDEADBEEF.
- Assert rst_i=0 mid-burst after beat 2 of 4 → rvalid_o=0 at the reset edge; after release arready_o=1 in the first cycle; memory still holds the preloaded words (re-read 0x0 returns 0x00000093).

Source files
------------

// File: rtl/axi_imem_rd_slave.sv
`default_nettype none
// ============================================================================
// Module  : axi_imem_rd_slave
// Brief   : AXI4 read-only instruction memory slave with preload port;
//           serves FIXED/INCR/WRAP bursts one beat per cycle.
// Revision: 1.0 - initial release
// ============================================================================
module axi_imem_rd_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          ID_W        = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_en_i,
  input  logic [31:0]     load_addr_i,
  input  logic [31:0]     load_data_i,
  input  logic            arvalid_i,
  input  logic [31:0]     araddr_i,
  input  logic [ID_W-1:0] arid_i,
  input  logic [7:0]      arlen_i,
  input  logic [1:0]      arburst_i,
  output logic            arready_o,
  output logic            rvalid_o,
  output logic [31:0]     rdata_o,
  output logic [1:0]      rresp_o,
  output logic [ID_W-1:0] rid_o,
  output logic            rlast_o,
  input  logic            rready_i
);

  localparam int          c_IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [31:0] c_SPAN  = 32'(DEPTH_WORDS * 4);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  state_t      r_state;
  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_addr;
  logic [7:0]  r_len;
  logic [7:0]  r_cnt;
  logic [1:0]  r_burst;
  logic        r_err;

  logic [31:0] w_ar_aligned;
  logic        w_ar_err;
  logic [31:0] w_wrap_mask;
  logic [31:0] w_next_addr;
  logic [31:0] w_fetch_addr;
  logic [31:0] w_fetch_off;
  logic        w_fetch_err;
  logic        w_fetch_last;
  logic        w_fetch_ok;
  logic [31:0] w_fetch_data;
  logic [31:0] w_load_addr;
  logic [31:0] w_load_off;
  logic        w_load_ok;

  // The beat to be presented next is fetched here: from the AR request while
  // idle, or from the successor of the current address while bursting.
  always_comb begin
    w_ar_aligned = araddr_i & ~32'h3;
    w_ar_err     = (arburst_i == 2'b11) ||
                   ((arburst_i == 2'b10) &&
                    !(arlen_i inside {8'd1, 8'd3, 8'd7, 8'd15}));
    w_wrap_mask  = {22'd0, r_len, 2'b11};
    case (r_burst)
      2'b00:   w_next_addr = r_addr;
      2'b10:   w_next_addr = (r_addr & ~w_wrap_mask) | ((r_addr + 32'd4) & w_wrap_mask);
      default: w_next_addr = r_addr + 32'd4;
    endcase
    if (r_state == S_IDLE) begin
      w_fetch_addr = w_ar_aligned;
      w_fetch_err  = w_ar_err;
      w_fetch_last = (arlen_i == 8'd0);
    end else begin
      w_fetch_addr = w_next_addr;
      w_fetch_err  = r_err;
      w_fetch_last = ((r_cnt + 8'd1) == r_len);
    end
    w_fetch_off  = w_fetch_addr - BASE_ADDR;
    w_fetch_ok   = !w_fetch_err && (w_fetch_addr >= BASE_ADDR) && (w_fetch_off < c_SPAN);
    w_fetch_data = w_fetch_ok ? r_mem[w_fetch_off[c_IDX_W+1:2]] : 32'd0;

    w_load_addr  = load_addr_i & ~32'h3;
    w_load_off   = w_load_addr - BASE_ADDR;
    w_load_ok    = (w_load_addr >= BASE_ADDR) && (w_load_off < c_SPAN);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i && load_en_i && w_load_ok) begin
      r_mem[w_load_off[c_IDX_W+1:2]] <= load_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state   <= S_IDLE;
      r_addr    <= 32'd0;
      r_len     <= 8'd0;
      r_cnt     <= 8'd0;
      r_burst   <= 2'b00;
      r_err     <= 1'b0;
      arready_o <= 1'b0;
      rvalid_o  <= 1'b0;
      rdata_o   <= 32'd0;
      rresp_o   <= 2'b00;
      rid_o     <= '0;
      rlast_o   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (arready_o && arvalid_i) begin
            r_state   <= S_BURST;
            r_addr    <= w_fetch_addr;
            r_len     <= arlen_i;
            r_cnt     <= 8'd0;
            r_burst   <= arburst_i;
            r_err     <= w_ar_err;
            arready_o <= 1'b0;
            rvalid_o  <= 1'b1;
            rdata_o   <= w_fetch_data;
            rresp_o   <= w_fetch_ok ? 2'b00 : 2'b10;
            rid_o     <= arid_i;
            rlast_o   <= w_fetch_last;
          end else begin
            arready_o <= 1'b1;
          end
        end
        S_BURST: begin
          if (rready_i) begin
            if (rlast_o) begin
              r_state   <= S_IDLE;
              arready_o <= 1'b1;
              rvalid_o  <= 1'b0;
              rlast_o   <= 1'b0;
            end else begin
              r_addr    <= w_fetch_addr;
              r_cnt     <= r_cnt + 8'd1;
              rdata_o   <= w_fetch_data;
              rresp_o   <= w_fetch_ok ? 2'b00 : 2'b10;
              rlast_o   <= w_fetch_last;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_imem_rd_slave.sv
`default_nettype none
// ============================================================================
// Module  : tb_axi_imem_rd_slave
// Brief   : Scoreboard bench for axi_imem_rd_slave burst reads and preload.
// Revision: 1.0 - initial release
// ============================================================================
module tb_axi_imem_rd_slave;

  localparam int DEPTH = 1024;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        load_en_i;
  logic [31:0] load_addr_i;
  logic [31:0] load_data_i;
  logic        arvalid_i;
  logic [31:0] araddr_i;
  logic [3:0]  arid_i;
  logic [7:0]  arlen_i;
  logic [1:0]  arburst_i;
  logic        arready_o;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic [1:0]  rresp_o;
  logic [3:0]  rid_o;
  logic        rlast_o;
  logic        rready_i;

  always #5 clk_i = ~clk_i;

  axi_imem_rd_slave #(
    .BASE_ADDR  (32'h0000_0000),
    .DEPTH_WORDS(DEPTH),
    .ID_W       (4)
  ) u_dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_en_i  (load_en_i),
    .load_addr_i(load_addr_i),
    .load_data_i(load_data_i),
    .arvalid_i  (arvalid_i),
    .araddr_i   (araddr_i),
    .arid_i     (arid_i),
    .arlen_i    (arlen_i),
    .arburst_i  (arburst_i),
    .arready_o  (arready_o),
    .rvalid_o   (rvalid_o),
    .rdata_o    (rdata_o),
    .rresp_o    (rresp_o),
    .rid_o      (rid_o),
    .rlast_o    (rlast_o),
    .rready_i   (rready_i)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [3:0]  id;
  } beat_t;

  beat_t       sb[$];
  logic [31:0] mdl [DEPTH];
  int          checks   = 0;
  int          errors   = 0;
  int          hs_count = 0;
  bit          bp_mode  = 1'b0;
  bit          stalled  = 1'b0;
  beat_t       held;
  beat_t       exp_beat;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic beat_t model_beat(input logic [31:0] addr, input logic [7:0] len,
                                       input logic [1:0] burst, input logic [3:0] id, input int i);
    beat_t       b;
    logic [31:0] a0, a, size, base;
    bit          err;
    a0  = addr & ~32'h3;
    err = (burst == 2'b11) ||
          (burst == 2'b10 && !(len == 1 || len == 3 || len == 7 || len == 15));
    case (burst)
      2'b00: a = a0;
      2'b10: begin
        size = (32'(len) + 32'd1) * 32'd4;
        base = a0 - (a0 % size);
        a    = base + ((a0 - base + 32'(4 * i)) % size);
      end
      default: a = a0 + 32'(4 * i);
    endcase
    b.id   = id;
    b.last = (i == int'(len));
    if (!err && a < 32'(DEPTH * 4)) begin
      b.data = mdl[a[11:2]];
      b.resp = 2'b00;
    end else begin
      b.data = 32'd0;
      b.resp = 2'b10;
    end
    return b;
  endfunction

  // R-channel observer: stability while stalled, scoreboard compare on handshake.
  always @(negedge clk_i) begin
    if (rst_i && stalled) begin
      check("hold_data", rdata_o, held.data);
      check("hold_last", 32'(rlast_o), 32'(held.last));
      check("hold_resp", 32'(rresp_o), 32'(held.resp));
      check("hold_id", 32'(rid_o), 32'(held.id));
    end
    stalled = rst_i && rvalid_o && !rready_i;
    if (stalled) held = '{data: rdata_o, resp: rresp_o, last: rlast_o, id: rid_o};
    if (rst_i && rvalid_o && rready_i) begin
      hs_count++;
      check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        exp_beat = sb.pop_front();
        check("rdata", rdata_o, exp_beat.data);
        check("rresp", 32'(rresp_o), 32'(exp_beat.resp));
        check("rlast", 32'(rlast_o), 32'(exp_beat.last));
        check("rid", 32'(rid_o), 32'(exp_beat.id));
      end
    end
  end

  initial begin
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int idx = 0;
    rready_i = 1'b1;
    forever begin
      @(posedge clk_i);
      #1;
      if (bp_mode) begin
        rready_i = pat[idx % 4];
        idx++;
      end else begin
        rready_i = 1'b1;
      end
    end
  end

  task automatic load_word(input logic [31:0] a, input logic [31:0] d);
    load_en_i   = 1'b1;
    load_addr_i = a;
    load_data_i = d;
    if (a < 32'(DEPTH * 4)) mdl[a[11:2]] = d;
    @(posedge clk_i);
    #1;
    load_en_i = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() > 0 && n < 200) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    check("drain", 32'(sb.size()), 32'd0);
    check("arready_after", 32'(arready_o), 32'd1);
    check("rvalid_after", 32'(rvalid_o), 32'd0);
  endtask

  task automatic issue(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                       input logic [3:0] id, input bit push, input bit wait_done);
    bit hs = 1'b0;
    int n  = 0;
    if (push) for (int i = 0; i <= int'(len); i++) sb.push_back(model_beat(addr, len, burst, id, i));
    arvalid_i = 1'b1;
    araddr_i  = addr;
    arlen_i   = len;
    arburst_i = burst;
    arid_i    = id;
    while (!hs && n < 50) begin
      @(negedge clk_i);
      hs = arready_o;
      @(posedge clk_i);
      #1;
      n++;
    end
    arvalid_i = 1'b0;
    check("ar_accept", 32'(hs), 32'd1);
    check("lat_rvalid", 32'(rvalid_o), 32'd1);
    check("ar_drop", 32'(arready_o), 32'd0);
    if (wait_done) wait_drain();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int base;
    beat_t e;
    rst_i       = 1'b0;
    load_en_i   = 1'b0;
    load_addr_i = 32'd0;
    load_data_i = 32'd0;
    arvalid_i   = 1'b0;
    araddr_i    = 32'd0;
    arid_i      = 4'd0;
    arlen_i     = 8'd0;
    arburst_i   = 2'b00;
    for (int i = 0; i < DEPTH; i++) mdl[i] = 32'd0;

    repeat (3) @(posedge clk_i);
    #1;
    check("rst_arready", 32'(arready_o), 32'd0);
    check("rst_rvalid", 32'(rvalid_o), 32'd0);
    check("rst_rdata", rdata_o, 32'd0);
    check("rst_rresp", 32'(rresp_o), 32'd0);
    check("rst_rid", 32'(rid_o), 32'd0);
    check("rst_rlast", 32'(rlast_o), 32'd0);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    check("arready_rise", 32'(arready_o), 32'd1);

    load_word(32'h0, 32'h0000_0093);
    load_word(32'h4, 32'h0010_0113);
    load_word(32'h8, 32'h0020_0193);
    load_word(32'hC, 32'h0030_0213);
    load_word(32'(DEPTH * 4 - 4), 32'hCAFE_F00D);

    issue(32'h0, 8'd3, 2'b01, 4'd5, 1'b1, 1'b1);   // INCR line fill
    issue(32'h8, 8'd3, 2'b10, 4'd6, 1'b1, 1'b1);   // WRAP 8,C,0,4

    bp_mode = 1'b1;
    base    = hs_count;
    issue(32'h0, 8'd3, 2'b01, 4'd3, 1'b1, 1'b1);
    check("bp_handshakes", 32'(hs_count - base), 32'd4);
    bp_mode = 1'b0;
    @(posedge clk_i);
    #1;

    issue(32'(DEPTH * 4 - 4), 8'd1, 2'b01, 4'd1, 1'b1, 1'b1);  // crosses end of memory
    issue(32'h0, 8'd2, 2'b10, 4'd2, 1'b1, 1'b1);               // illegal WRAP length
    issue(32'h4, 8'd2, 2'b11, 4'd4, 1'b1, 1'b1);               // reserved burst

    for (int i = 0; i < 3; i++) begin
      e = model_beat(32'h4, 8'd2, 2'b00, 4'd7, i);
      if (i == 2) e.data = 32'hDEAD_BEEF;
      sb.push_back(e);
    end
    issue(32'h4, 8'd2, 2'b00, 4'd7, 1'b0, 1'b0);
    load_word(32'h4, 32'hDEAD_BEEF);   // lands on beat 1's handshake edge
    wait_drain();

    base = hs_count;
    issue(32'h0, 8'd3, 2'b01, 4'd9, 1'b1, 1'b0);
    for (int n = 0; n < 50 && hs_count < base + 2; n++) begin
      @(posedge clk_i);
      #1;
    end
    check("rst_mid_beats", 32'(hs_count - base), 32'd2);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    check("rst_mid_rvalid", 32'(rvalid_o), 32'd0);
    check("rst_mid_rlast", 32'(rlast_o), 32'd0);
    sb.delete();
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    check("rst_rel_arready", 32'(arready_o), 32'd1);
    issue(32'h0, 8'd0, 2'b01, 4'd2, 1'b1, 1'b1);

    repeat (2) @(posedge clk_i);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
